// File: rtl/pll_video_reconfig_pkg.sv
// ============================================================================
// Package : pll_reconfig_pkg
// Brief   : Shared types and constants for the video PLL reconfiguration block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_MODE   = 3'd1,
        ST_WR_M      = 3'd2,
        ST_WR_K      = 3'd3,
        ST_WR_START  = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_WAIT_LOCK = 3'd6
    } state_t;

    localparam logic [5:0]  C_ADDR_MODE  = 6'd0;
    localparam logic [5:0]  C_ADDR_START = 6'd2;
    localparam logic [5:0]  C_ADDR_M     = 6'd4;
    localparam logic [5:0]  C_ADDR_K     = 6'd7;

    localparam logic        C_MODE_NTSC  = 1'b0;
    localparam logic        C_MODE_PAL   = 1'b1;

    // Mode register 0 selects waitrequest mode; start register kicks the reconfiguration.
    localparam logic [31:0] C_DATA_WAITREQ_MODE = 32'd0;
    localparam logic [31:0] C_DATA_START        = 32'd1;

    function automatic logic [31:0] mode_word(input logic        tgt,
                                              input logic [31:0] pal_word,
                                              input logic [31:0] ntsc_word);
        return (tgt == C_MODE_PAL) ? pal_word : ntsc_word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_video_reconfig_if.sv
// ============================================================================
// Interface : pll_video_reconfig_if
// Brief     : Avalon-MM write-only management bus to the PLL reconfig core.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface pll_video_reconfig_if;

    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address,
        output mgmt_write,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );

endinterface

`default_nettype wire

// File: rtl/pll_video_reconfig_sync2.sv
// ============================================================================
// Module : sync2
// Brief  : Two-flop synchroniser for a single asynchronous level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_video_reconfig.sv
// ============================================================================
// Module : pll_video_reconfig
// Brief  : Retunes the video PLL between NTSC and PAL via the reconfig core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_video_reconfig
    import pll_reconfig_pkg::*;
#(
    parameter logic [31:0] NTSC_M       = 32'h0000_0404,
    parameter logic [31:0] NTSC_K       = 32'h9745_BF27,
    parameter logic [31:0] PAL_M        = 32'h0000_0404,
    parameter logic [31:0] PAL_K        = 32'h8336_55D2,
    parameter int          LOCK_TIMEOUT = 1000000,
    parameter int          MAX_RETRY    = 3
) (
    input  wire logic              refclk,
    input  wire logic              rst,
    input  wire logic              pal,
    input  wire logic              pll_locked,
    pll_video_reconfig_if.master   mgmt,
    output logic                   busy,
    output logic                   pal_active,
    output logic                   cfg_done,
    output logic                   cfg_error
);

    localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] C_RTY_MAX  = RTY_W'(MAX_RETRY);

    logic pal_s;
    logic locked_s;

    sync2 u_sync_pal (
        .clk (refclk),
        .rst (rst),
        .d_i (pal),
        .q_o (pal_s)
    );

    sync2 u_sync_locked (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    state_t           state_q,      state_d;
    logic             tgt_q,        tgt_d;
    logic             valid_q,      valid_d;
    logic             pal_active_q, pal_active_d;
    logic             cfg_done_q,   cfg_done_d;
    logic             cfg_error_q,  cfg_error_d;
    logic [RTY_W-1:0] retry_q,      retry_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic             wr_en;
    logic [5:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             timeout;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tgt_q        <= C_MODE_NTSC;
            valid_q      <= 1'b0;
            pal_active_q <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_error_q  <= 1'b0;
            retry_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            valid_q      <= valid_d;
            pal_active_q <= pal_active_d;
            cfg_done_q   <= cfg_done_d;
            cfg_error_q  <= cfg_error_d;
            retry_q      <= retry_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        valid_d      = valid_q;
        pal_active_d = pal_active_q;
        cfg_done_d   = 1'b0;
        cfg_error_d  = cfg_error_q;
        retry_d      = retry_q;
        cnt_d        = cnt_q;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        timeout      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!valid_q || (pal_s != pal_active_q)) begin
                    tgt_d   = pal_s;
                    state_d = ST_WR_MODE;
                end
            end
            // Bus outputs are decoded from held state, so they stay stable under waitrequest.
            ST_WR_MODE: begin
                wr_en   = 1'b1;
                wr_addr = C_ADDR_MODE;
                wr_data = C_DATA_WAITREQ_MODE;
                if (!mgmt.mgmt_waitrequest) state_d = ST_WR_M;
            end
            ST_WR_M: begin
                wr_en   = 1'b1;
                wr_addr = C_ADDR_M;
                wr_data = mode_word(tgt_q, PAL_M, NTSC_M);
                if (!mgmt.mgmt_waitrequest) state_d = ST_WR_K;
            end
            ST_WR_K: begin
                wr_en   = 1'b1;
                wr_addr = C_ADDR_K;
                wr_data = mode_word(tgt_q, PAL_K, NTSC_K);
                if (!mgmt.mgmt_waitrequest) state_d = ST_WR_START;
            end
            ST_WR_START: begin
                wr_en   = 1'b1;
                wr_addr = C_ADDR_START;
                wr_data = C_DATA_START;
                if (!mgmt.mgmt_waitrequest) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (cnt_q >= C_CNT_LAST)          timeout = 1'b1;
                else if (!mgmt.mgmt_waitrequest)  state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                cnt_d = cnt_inc;
                if (locked_s) begin
                    pal_active_d = tgt_q;
                    valid_d      = 1'b1;
                    cfg_done_d   = 1'b1;
                    cfg_error_d  = 1'b0;
                    retry_d      = '0;
                    state_d      = ST_IDLE;
                end else if (cnt_q >= C_CNT_LAST) begin
                    timeout = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Retries reuse the latched target; after the last one give up and report.
        if (timeout) begin
            if (retry_q < C_RTY_MAX) begin
                retry_d = retry_q + RTY_W'(1);
                state_d = ST_WR_MODE;
            end else begin
                cfg_error_d  = 1'b1;
                valid_d      = 1'b1;
                pal_active_d = tgt_q;
                retry_d      = '0;
                state_d      = ST_IDLE;
            end
        end
    end

    assign mgmt.mgmt_write     = wr_en;
    assign mgmt.mgmt_address   = wr_addr;
    assign mgmt.mgmt_writedata = wr_data;

    assign busy       = (state_q != ST_IDLE);
    assign pal_active = pal_active_q;
    assign cfg_done   = cfg_done_q;
    assign cfg_error  = cfg_error_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_video_reconfig.sv
// ============================================================================
// Module : tb_pll_video_reconfig
// Brief  : Scoreboard bench with a reconfig-core/PLL model for pll_video_reconfig.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_video_reconfig;

    localparam int LT = 100;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    logic refclk;
    logic rst;
    logic pal;
    logic pll_locked;
    logic busy;
    logic pal_active;
    logic cfg_done;
    logic cfg_error;

    pll_video_reconfig_if mgmt();

    pll_video_reconfig #(.LOCK_TIMEOUT(LT)) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pal        (pal),
        .pll_locked (pll_locked),
        .mgmt       (mgmt),
        .busy       (busy),
        .pal_active (pal_active),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error)
    );

    wr_t  exp_wr[$];
    logic exp_done[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int wr_cnt    = 0;
    int done_cnt  = 0;
    int stall_cnt = 0;
    int first_wr_cyc = 0;
    int last_wr_cyc  = 0;
    int done_cyc     = 0;
    int start_gap    = 0;
    int wr_stall     = 0;
    int lock_lat     = 5;
    bit lock_en      = 1'b1;

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    initial forever begin
        @(posedge refclk);
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_burst(input logic p);
        exp_wr.push_back(wr_t'{6'd0, 32'h0000_0000});
        exp_wr.push_back(wr_t'{6'd4, 32'h0000_0404});
        exp_wr.push_back(wr_t'{6'd7, p ? 32'h8336_55D2 : 32'h9745_BF27});
        exp_wr.push_back(wr_t'{6'd2, 32'h0000_0001});
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 64'(n < budget), 64'd1);
    endtask

    // Reconfig core and PLL model: per-write stall, lock drops on reconfig, relocks after start.
    initial begin
        int stall_left;
        bit start_pend;
        int lock_cnt;
        mgmt.mgmt_waitrequest = 1'b0;
        pll_locked = 1'b0;
        stall_left = 0;
        start_pend = 1'b0;
        lock_cnt   = 0;
        forever begin
            step();
            if (rst) begin
                mgmt.mgmt_waitrequest = 1'b0;
                stall_left = wr_stall;
                start_pend = 1'b0;
                lock_cnt   = 0;
            end else begin
                if (start_pend) begin
                    lock_cnt   = lock_lat;
                    start_pend = 1'b0;
                end else if (lock_cnt > 0) begin
                    lock_cnt--;
                    if (lock_cnt == 0 && lock_en) pll_locked = 1'b1;
                end
                if (mgmt.mgmt_write) begin
                    if (mgmt.mgmt_address == 6'd0) pll_locked = 1'b0;
                    if (stall_left > 0) begin
                        mgmt.mgmt_waitrequest = 1'b1;
                        stall_left--;
                    end else begin
                        mgmt.mgmt_waitrequest = 1'b0;
                        stall_left = wr_stall;
                        if (mgmt.mgmt_address == 6'd2) start_pend = 1'b1;
                    end
                end else begin
                    mgmt.mgmt_waitrequest = 1'b0;
                    stall_left = wr_stall;
                end
            end
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    initial begin
        bit  hold_prev;
        wr_t held;
        wr_t e;
        hold_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge refclk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (mgmt.mgmt_write && hold_prev) begin
                    check_eq("hold_addr", 64'(mgmt.mgmt_address),   64'(held.a));
                    check_eq("hold_data", 64'(mgmt.mgmt_writedata), 64'(held.d));
                end
                hold_prev = mgmt.mgmt_write && mgmt.mgmt_waitrequest;
                held = wr_t'{mgmt.mgmt_address, mgmt.mgmt_writedata};
                if (hold_prev) stall_cnt++;
                if (mgmt.mgmt_write && !mgmt.mgmt_waitrequest) begin
                    check_eq("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
                    if (exp_wr.size() > 0) begin
                        e = exp_wr.pop_front();
                        check_eq("wr_addr", 64'(mgmt.mgmt_address),   64'(e.a));
                        check_eq("wr_data", 64'(mgmt.mgmt_writedata), 64'(e.d));
                    end
                    if (mgmt.mgmt_address == 6'd0) begin
                        first_wr_cyc = cyc;
                        start_gap    = cyc - done_cyc;
                    end else if (wr_stall == 0) begin
                        check_eq("consec", 64'(cyc - last_wr_cyc), 64'd1);
                    end
                    last_wr_cyc = cyc;
                    wr_cnt++;
                end
                if (cfg_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check_eq("done_expected", 64'(exp_done.size() > 0), 64'd1);
                    if (exp_done.size() > 0) check_eq("done_pal", 64'(pal_active), 64'(exp_done.pop_front()));
                end
            end
        end
    end

    initial begin
        int t0;
        int w0;
        int d0;
        int s0;
        int n;
        rst = 1'b1;
        pal = 1'b0;
        repeat (3) step();
        check_eq("rst_write", 64'(mgmt.mgmt_write),     64'd0);
        check_eq("rst_addr",  64'(mgmt.mgmt_address),   64'd0);
        check_eq("rst_data",  64'(mgmt.mgmt_writedata), 64'd0);
        check_eq("rst_busy",  64'(busy),       64'd0);
        check_eq("rst_pal",   64'(pal_active), 64'd0);
        check_eq("rst_done",  64'(cfg_done),   64'd0);
        check_eq("rst_err",   64'(cfg_error),  64'd0);

        // First sequence after reset programs NTSC
        push_burst(1'b0);
        exp_done.push_back(1'b0);
        rst = 1'b0;
        wait_idle("t1_idle", 300);
        check_eq("t1_pal_active", 64'(pal_active), 64'd0);
        check_eq("t1_done_cnt",   64'(done_cnt),   64'd1);
        check_eq("t1_wr_cnt",     64'(wr_cnt),     64'd4);

        // Toggle to PAL in IDLE: burst starts three cycles later
        step();
        pal = 1'b1;
        t0 = cyc;
        push_burst(1'b1);
        exp_done.push_back(1'b1);
        wait_idle("t2_idle", 300);
        check_eq("t2_latency",    64'(first_wr_cyc - t0), 64'd3);
        check_eq("t2_pal_active", 64'(pal_active), 64'd1);

        // Four-cycle waitrequest on each write
        wr_stall = 4;
        w0 = wr_cnt;
        s0 = stall_cnt;
        step();
        pal = 1'b0;
        push_burst(1'b0);
        exp_done.push_back(1'b0);
        wait_idle("t3_idle", 400);
        check_eq("t3_wr_cnt",     64'(wr_cnt - w0),    64'd4);
        check_eq("t3_stalls",     64'(stall_cnt - s0), 64'd16);
        check_eq("t3_pal_active", 64'(pal_active), 64'd0);
        wr_stall = 0;

        // Toggle during WAIT_LOCK: old target finishes, new burst follows immediately
        lock_lat = 20;
        d0 = done_cnt;
        step();
        pal = 1'b1;
        push_burst(1'b1);
        exp_done.push_back(1'b1);
        n = 0;
        while (exp_wr.size() != 0 && n < 200) begin step(); n++; end
        check_eq("t4_burst_seen", 64'(n < 200), 64'd1);
        repeat (3) step();
        pal = 1'b0;
        push_burst(1'b0);
        exp_done.push_back(1'b0);
        wait_idle("t4_idle", 400);
        check_eq("t4_done_cnt",   64'(done_cnt - d0), 64'd2);
        check_eq("t4_b2b_gap",    64'(start_gap),     64'd1);
        check_eq("t4_pal_active", 64'(pal_active),    64'd0);
        lock_lat = 5;

        // Lock never arrives: initial attempt plus three retries, then error
        lock_en = 1'b0;
        w0 = wr_cnt;
        d0 = done_cnt;
        step();
        pal = 1'b1;
        repeat (4) push_burst(1'b1);
        wait_idle("t5_idle", 3000);
        check_eq("t5_wr_cnt",     64'(wr_cnt - w0),   64'd16);
        check_eq("t5_no_done",    64'(done_cnt - d0), 64'd0);
        check_eq("t5_err",        64'(cfg_error),     64'd1);
        check_eq("t5_busy",       64'(busy),          64'd0);
        check_eq("t5_pal_active", 64'(pal_active),    64'd1);
        repeat (10) step();
        check_eq("t5_stays_idle", 64'(busy),          64'd0);
        check_eq("t5_no_rewrite", 64'(wr_cnt - w0),   64'd16);

        // Successful sequence clears the error
        lock_en = 1'b1;
        step();
        pal = 1'b0;
        push_burst(1'b0);
        exp_done.push_back(1'b0);
        wait_idle("t6_idle", 300);
        check_eq("t6_err_clr",    64'(cfg_error),  64'd0);
        check_eq("t6_pal_active", 64'(pal_active), 64'd0);

        // Reset during WR_K abandons the burst; restart from WR_MODE
        wr_stall = 4;
        step();
        pal = 1'b1;
        push_burst(1'b1);
        exp_done.push_back(1'b1);
        n = 0;
        while (!(mgmt.mgmt_write && mgmt.mgmt_address == 6'd7) && n < 200) begin
            @(negedge refclk);
            n++;
        end
        check_eq("t7_wrk_seen", 64'(n < 200), 64'd1);
        #3 rst = 1'b1;
        #1;
        check_eq("t7_async_wr",   64'(mgmt.mgmt_write), 64'd0);
        check_eq("t7_async_busy", 64'(busy),            64'd0);
        exp_wr.delete();
        exp_done.delete();
        pal = 1'b0;
        repeat (3) step();
        check_eq("t7_rst_pal",  64'(pal_active), 64'd0);
        check_eq("t7_rst_err",  64'(cfg_error),  64'd0);
        w0 = wr_cnt;
        push_burst(1'b0);
        exp_done.push_back(1'b0);
        rst = 1'b0;
        wait_idle("t7_idle", 400);
        check_eq("t7_wr_cnt",     64'(wr_cnt - w0), 64'd4);
        check_eq("t7_pal_active", 64'(pal_active),  64'd0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
